mem_access_stage: RTL

Data-memory stage of the five-stage pipeline CPU, placed between the EX/MEM and MEM/WB registers and replacing the bare word-only data RAM. It executes word, halfword and byte loads and stores against an internal synchronous RAM. Sub-word loads are returned sign- or zero-extended. Sub-word stores are done as a two-cycle read-modify-write, and `MemStall` freezes the upstream pipeline for the extra cycle.

---
 rtl/mem_pkg.sv | 32 +++
 rtl/data_ram_sync.sv | 26 ++
 rtl/mem_access_stage.sv | 139 +++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory stage: access sizes, FSM state type
// and the load lane-select/extend helper.
package mem_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic {IDLE = 1'b0, MERGE = 1'b1} mstate_e;

   // Pick the byte/half lane out of a little-endian word and extend it.
   function automatic logic [31:0] extract(input logic [31:0] w,
                                           input logic [1:0]  sz,
                                           input logic [1:0]  off,
                                           input logic        sgn);
      logic [7:0]  b;
      logic [15:0] h;
      case (off)
         2'd0:    b = w[7:0];
         2'd1:    b = w[15:8];
         2'd2:    b = w[23:16];
         default: b = w[31:24];
      endcase
      h = off[1] ? w[31:16] : w[15:0];
      case (sz)
         SZ_BYTE: return {{24{sgn & b[7]}}, b};
         SZ_HALF: return {{16{sgn & h[15]}}, h};
         default: return w;
      endcase
   endfunction

endpackage

// File: rtl/data_ram_sync.sv
// DEPTH x 32 synchronous RAM: one write port, one read port with a read enable
// so the output register holds when no read is requested.
module data_ram_sync #(
   parameter int DEPTH = 64,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk_i,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [31:0]   wdata_i,
   input  logic          re_i,
   input  logic [AW-1:0] raddr_i,
   output logic [31:0]   rdata_o
);

   logic [31:0] mem_q [DEPTH];
   logic [31:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
      if (re_i) rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage with byte/half/word loads and stores over a synchronous RAM.
// Sub-word support (two-cycle read-modify-write stores) needs MEM_SUBWORD_EN.
module mem_access_stage
   import mem_pkg::*;
#(
   parameter int DEPTH = 64,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemRead_mem,
   input  logic        MemWrite_mem,
   input  logic [1:0]  MemSize_mem,
   input  logic        MemSigned_mem,
   input  logic [31:0] Addr_mem,
   input  logic [31:0] WriteData_mem,
   output logic [31:0] MemDout_wb,
   output logic        MemStall,
   output logic        AddrErr
);

   logic [AW-1:0] idx;
   logic [1:0]    size_eff;
   logic          sgn_eff, in_merge, misal, is_ld, word_st, sub_st;
   logic          ram_we, ram_re;
   logic [AW-1:0] ram_waddr;
   logic [31:0]   ram_wdata, rdata;

   logic          ld_q, lerr_q, sgn_q;
   logic [1:0]    size_q, off_q;
   logic [31:0]   hold_q;

   assign idx = Addr_mem[AW+1:2];

`ifdef MEM_SUBWORD_EN
   mstate_e       state_q;
   logic [15:0]   data_q;
   logic [AW-1:0] idx_q;
   logic [31:0]   merged;
   logic          unused_hi;

   assign unused_hi = ^Addr_mem[31:AW+2];
   assign size_eff  = (MemSize_mem == 2'b11) ? SZ_WORD : MemSize_mem;
   assign sgn_eff   = MemSigned_mem;
   assign in_merge  = (state_q == MERGE);
   assign MemStall  = sub_st;

   always_comb begin
      merged = rdata;
      if (size_q == SZ_HALF) begin
         if (off_q[1]) merged[31:16] = data_q;
         else          merged[15:0]  = data_q;
      end else begin
         case (off_q)
            2'd0:    merged[7:0]   = data_q[7:0];
            2'd1:    merged[15:8]  = data_q[7:0];
            2'd2:    merged[23:16] = data_q[7:0];
            default: merged[31:24] = data_q[7:0];
         endcase
      end
   end

   assign ram_waddr = in_merge ? idx_q  : idx;
   assign ram_wdata = in_merge ? merged : WriteData_mem;

   // Merge state keeps its own copy of the store; held upstream inputs are not trusted.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         data_q  <= '0;
         idx_q   <= '0;
      end else begin
         case (state_q)
            IDLE: if (sub_st) begin
               state_q <= MERGE;
               data_q  <= WriteData_mem[15:0];
               idx_q   <= idx;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
`else
   logic unused_in;

   assign unused_in = ^{Addr_mem[31:AW+2], MemSize_mem, MemSigned_mem};
   assign size_eff  = SZ_WORD;
   assign sgn_eff   = 1'b0;
   assign in_merge  = 1'b0;
   assign MemStall  = 1'b0;
   assign ram_waddr = idx;
   assign ram_wdata = WriteData_mem;
`endif

   assign misal   = ((size_eff == SZ_HALF) & Addr_mem[0]) |
                    ((size_eff == SZ_WORD) & (|Addr_mem[1:0]));
   // Read+write together is a store, so loads need MemWrite low.
   assign is_ld   = !in_merge && MemRead_mem && !MemWrite_mem;
   assign word_st = !in_merge && MemWrite_mem && (size_eff == SZ_WORD) && !misal;
   assign sub_st  = !in_merge && MemWrite_mem && (size_eff != SZ_WORD) && !misal;
   assign AddrErr = !in_merge && (MemRead_mem || MemWrite_mem) && misal;

   assign ram_we  = !reset && (in_merge || word_st);
   assign ram_re  = (is_ld && !misal) || sub_st;

   data_ram_sync #(.DEPTH(DEPTH), .AW(AW)) u_ram (
      .clk_i   (clk),
      .we_i    (ram_we),
      .waddr_i (ram_waddr),
      .wdata_i (ram_wdata),
      .re_i    (ram_re),
      .raddr_i (idx),
      .rdata_o (rdata)
   );

   assign MemDout_wb = !ld_q  ? hold_q :
                       lerr_q ? 32'h0  : extract(rdata, size_q, off_q, sgn_q);

   always_ff @(posedge clk) begin
      if (reset) begin
         ld_q   <= 1'b0;
         lerr_q <= 1'b0;
         sgn_q  <= 1'b0;
         size_q <= SZ_BYTE;
         off_q  <= 2'b00;
         hold_q <= '0;
      end else begin
         hold_q <= MemDout_wb;
         ld_q   <= is_ld;
         lerr_q <= is_ld && misal;
         if (is_ld || sub_st) begin
            size_q <= size_eff;
            off_q  <= Addr_mem[1:0];
            sgn_q  <= sgn_eff;
         end
      end
   end

endmodule
